// File: rtl/andchain_trace_driver.sv
// ---------------------------------------------------------------------------
// andchain_trace_driver
//
// Drives pseudo-random stimulus (a/b/c) into a LANES-wide AND-chain under
// test and records every run cycle's stimulus and response into a trace FIFO
// for a downstream consumer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a run (only looked at in IDLE)
//   stop                end a run early (only looked at in RUN)
//   run_len[15:0]       cycles per run, 0 = run until stop
//   a, b, c             registered stimulus, bit i = lane i
//   d, e, f             chain responses, bit i = lane i
//   trace_valid/ready   head-of-FIFO handshake
//   trace_data          head entry {d,e,f,a,b,c}
//   busy                high in RUN or DRAIN
//   done                one-cycle pulse on DRAIN->IDLE
//   overflow            sticky, at least one sample was dropped
//   drop_cnt[7:0]       saturating dropped-sample count
//
// Build option
//   ANDCHAIN_TRACE_DROPCNT_EN  enables drop_cnt; otherwise drop_cnt is 0 and
//                              only overflow flags drops.
// ---------------------------------------------------------------------------
module andchain_trace_driver #(
    parameter int          LANES = 5,
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [15:0]          run_len,
    output logic [LANES-1:0]     a,
    output logic [LANES-1:0]     b,
    output logic [LANES-1:0]     c,
    input  logic [LANES-1:0]     d,
    input  logic [LANES-1:0]     e,
    input  logic [LANES-1:0]     f,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [6*LANES-1:0]   trace_data,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = 6 * LANES;
    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [15:0]     lfsr, lfsr_nxt;
    logic [15:0]     run_cnt;
    logic [AW:0]     count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [W-1:0]    mem [DEPTH];

    logic start_run, run_term;
    logic push, pop, full, push_ok, drop;

    // x^16+x^14+x^13+x^11+1, right-shifting Galois form.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    assign start_run = (state == IDLE) && start;
    // stop and the length terminal OR together, so both at once still give
    // exactly one RUN->DRAIN transition.
    assign run_term  = stop || ((run_len != 16'd0) && (run_cnt == run_len - 16'd1));

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned -- otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    lfsr_nxt  = SEED_EFF;
                end
            end
            RUN: begin
                lfsr_nxt = lfsr_step(lfsr);
                if (run_term) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (count == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= SEED;
            run_cnt <= '0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= lfsr_nxt;
            done  <= (state == DRAIN) && (count == '0);
            if (start_run)
                run_cnt <= '0;
            else if (state == RUN && run_cnt != 16'hFFFF)
                run_cnt <= run_cnt + 16'd1;
            // a/b/c always present the LFSR state that is current in the RUN
            // cycle they belong to, i.e. the value being loaded now.
            if (state_nxt == RUN) begin
                a <= lfsr_nxt[LANES-1:0];
                b <= lfsr_nxt[5+LANES-1:5];
                c <= lfsr_nxt[10+LANES-1:10];
            end else begin
                a <= '0;
                b <= '0;
                c <= '0;
            end
        end
    end

    assign busy = (state != IDLE);

    // -----------------------------------------------------------------------
    // Trace FIFO
    // -----------------------------------------------------------------------
    assign push    = (state == RUN);
    assign pop     = (count != '0) && trace_ready;
    assign full    = (count == (AW+1)'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; emptiness is defined by the pointers and
    // count alone, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {d, e, f, a, b, c};
    end

    assign trace_valid = (count != '0);
    assign trace_data  = mem[rd_ptr];

    // -----------------------------------------------------------------------
    // Drop reporting
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         overflow <= 1'b0;
        else if (start_run) overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
    end

`ifdef ANDCHAIN_TRACE_DROPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          drop_cnt <= '0;
        else if (start_run)                  drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_andchain_trace_driver.sv
// ---------------------------------------------------------------------------
// tb_andchain_trace_driver
//
// Cycle-level scoreboard bench: a behavioural model of the run FSM, LFSR and
// trace FIFO predicts every output each cycle; expected trace entries are
// queued when a run cycle is driven and compared when the DUT pops them.
// ---------------------------------------------------------------------------
module tb_andchain_trace_driver;

    localparam int          LANES = 5;
    localparam int          DEPTH = 16;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          W     = 6 * LANES;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, stop, trace_ready;
    logic [15:0]        run_len;
    logic [LANES-1:0]   a, b, c, d, e, f;
    logic               trace_valid, busy, done, overflow;
    logic [W-1:0]       trace_data;
    logic [7:0]         drop_cnt;

    andchain_trace_driver #(.LANES(LANES), .SEED(SEED), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .run_len(run_len),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .busy(busy), .done(done),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_DRAIN} m_state_t;
    m_state_t        m_state;
    logic [15:0]     m_lfsr, m_cnt;
    logic            m_ovf, m_done;
    int              m_drops;
    logic [W-1:0]    m_q[$];
    int              pops;
    bit              rand_ready = 0;

    function automatic logic [15:0] m_adv(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic m_reset();
        m_state = M_IDLE; m_lfsr = SEED; m_cnt = 0;
        m_ovf = 0; m_done = 0; m_drops = 0;
        m_q.delete();
    endtask

    // One clock cycle: called at a falling edge with inputs already set,
    // checks outputs, advances the model, returns at the next falling edge.
    task automatic step();
        logic [LANES-1:0] ea, eb, ec;
        logic             p, term;
        int               sz;
        d = LANES'($urandom); e = LANES'($urandom); f = LANES'($urandom);
        if (rand_ready) trace_ready = 1'($urandom);
        #1;
        ea = (m_state == M_RUN) ? m_lfsr[LANES-1:0]    : '0;
        eb = (m_state == M_RUN) ? m_lfsr[5+LANES-1:5]  : '0;
        ec = (m_state == M_RUN) ? m_lfsr[10+LANES-1:10] : '0;
        check("busy", busy, m_state != M_IDLE);
        check("done", done, m_done);
        check("a", a, ea);
        check("b", b, eb);
        check("c", c, ec);
        check("trace_valid", trace_valid, m_q.size() != 0);
        check("overflow", overflow, m_ovf);
`ifdef ANDCHAIN_TRACE_DROPCNT_EN
        check("drop_cnt", drop_cnt, m_drops);
`else
        check("drop_cnt", drop_cnt, 0);
`endif
        if (trace_valid && trace_ready) pops++;
        sz = m_q.size();
        p  = (sz != 0) && trace_ready;
        if (p) begin
            check("trace_data", trace_data, m_q[0]);
            void'(m_q.pop_front());
        end
        m_done = 0;
        case (m_state)
            M_IDLE: if (start) begin
                m_state = M_RUN; m_lfsr = (SEED == 0) ? 16'h1 : SEED;
                m_cnt = 0; m_ovf = 0; m_drops = 0;
            end
            M_RUN: begin
                if (sz == DEPTH && !p) begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_q.push_back({d, e, f, ea, eb, ec});
                end
                term = stop || (run_len != 0 && m_cnt == run_len - 16'd1);
                if (m_cnt != 16'hFFFF) m_cnt++;
                m_lfsr = m_adv(m_lfsr);
                if (term) m_state = M_DRAIN;
            end
            M_DRAIN: if (sz == 0) begin
                m_state = M_IDLE; m_done = 1;
            end
            default: m_state = M_IDLE;
        endcase
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((m_state != M_IDLE || m_done) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("timeout", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0; start = 0; stop = 0; run_len = 0; trace_ready = 0;
        d = '0; e = '0; f = '0;
        m_reset();
        pops = 0;
        @(negedge clk);
        step(); step();              // outputs held in reset
        rst_n = 1;
        step();

        // Single-cycle run: first RUN cycle values are known constants.
        run_len = 16'd1; trace_ready = 1; start = 1;
        step();
        start = 0;
        #1;
        check("first_a", a, 5'b00001);
        check("first_b", b, 5'b00111);
        check("first_c", c, 5'b01011);
        step();
        run_until_idle(50);

        // Overflow: 20 samples into 16 entries with no consumer.
        run_len = 16'd20; trace_ready = 0; start = 1;
        step();
        start = 0;
        repeat (22) step();
        #1;
        check("ovf_sticky", overflow, 1);
`ifdef ANDCHAIN_TRACE_DROPCNT_EN
        check("ovf_drops", drop_cnt, 4);
`else
        check("ovf_drops", drop_cnt, 0);
`endif
        check("ovf_busy", busy, 1);
        pops = 0; trace_ready = 1;
        step();
        run_until_idle(60);
        check("ovf_pops", pops, 16);

        // Open-ended run ended by stop during the 10th RUN cycle.
        run_len = 16'd0; rand_ready = 1; start = 1;
        step();
        start = 0;
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            stop = (k == 9);
            step();
        end
        stop = 0;
        run_until_idle(300);
        rand_ready = 0; trace_ready = 1;
        check("stop_pops", pops, 10);
        check("stop_busy", busy, 0);

        // Full FIFO with a consumer present: push and pop share the cycle.
        run_len = 16'd30; trace_ready = 0; start = 1;
        step();
        start = 0;
        repeat (16) step();
        trace_ready = 1;
        run_until_idle(80);
        check("full_rdy_ovf", overflow, 0);
        check("full_rdy_drops", drop_cnt, 0);

        // Ignored controls: stop while idle, start held during a run.
        stop = 1;
        repeat (3) step();
        stop = 0;
        run_len = 16'd8; start = 1;
        step();
        repeat (8) step();
        start = 0;
        run_until_idle(40);

        // Reset mid-run with 5 entries queued.
        run_len = 16'd0; trace_ready = 0; start = 1;
        step();
        start = 0;
        repeat (5) step();
        rst_n = 0;
        #1;
        check("rst_valid", trace_valid, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_c", c, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        m_reset();
        step();
        rst_n = 1; trace_ready = 1;
        step(); step();

        // Recovery run after reset.
        run_len = 16'd3; start = 1;
        step();
        start = 0;
        run_until_idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/andchain_trace_driver.md
ANDCHAIN_TRACE_DRIVER -- requirements
Module: andchain_trace_driver

Interface
REQ-001 The block SHALL have parameter LANES, default 5, number of a/b/c/d/e/f lanes driven and monitored (legal range 1..5).
REQ-002 The block SHALL have parameter SEED, default 16'hACE1, initial LFSR state.
REQ-003 The block SHALL have parameter DEPTH, default 16, trace FIFO entries (power of two, 2..256).
REQ-004 The block SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port start  in  1  begin a run, sampled only in IDLE.
REQ-007 The block SHALL have port stop  in  1  end a run early, sampled only in RUN.
REQ-008 The block SHALL have port run_len  in  16  cycles per run; 0 = run until stop.
REQ-009 The block SHALL have ports a, b, c  out  LANES each  stimulus toward the chain's a_i/b_i/c_i inputs, bit i = lane i.
REQ-010 The block SHALL have ports d, e, f  in  LANES each  responses from the chain's d_i/e_i/f_i outputs.
REQ-011 The block SHALL have port trace_valid  out  1  FIFO non-empty.
REQ-012 The block SHALL have port trace_ready  in  1  consumer accepts head entry.
REQ-013 The block SHALL have port trace_data  out  6*LANES  head entry {d,e,f,a,b,c}.
REQ-014 The block SHALL have port busy  out  1  high in RUN or DRAIN.
REQ-015 The block SHALL have port done  out  1  one-cycle pulse on DRAIN->IDLE.
REQ-016 The block SHALL have port overflow  out  1  sticky, a sample was dropped.
REQ-017 The block SHALL have port drop_cnt  out  8  dropped-sample count (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN.
- IDLE->RUN on start.
- RUN->DRAIN on stop, or when the run counter reaches run_len-1 with run_len != 0.
- DRAIN->IDLE when FIFO empty.
REQ-019 On IDLE->RUN the block SHALL load LFSR with SEED (16'h0001 if SEED==0), clear run counter, overflow, drop_cnt.
REQ-020 The LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advancing once per RUN cycle.
REQ-021 In RUN the block SHALL drive a=lfsr[LANES-1:0], b=lfsr[5+LANES-1:5], c=lfsr[10+LANES-1:10] from the current (pre-advance) LFSR state, registered.
REQ-022 In IDLE and DRAIN, a, b, c SHALL be 0.
REQ-023 Each RUN cycle the block SHALL push {d,e,f,a,b,c} (current driven a/b/c, current d/e/f inputs) into the FIFO.
REQ-024 A push when FIFO full and no pop SHALL drop the sample, set overflow, increment drop_cnt (saturating at 255).
REQ-025 A push and pop in the same cycle when full SHALL both succeed; occupancy unchanged.
REQ-026 Pop SHALL occur when trace_valid && trace_ready; trace_data SHALL be stable while trace_valid && !trace_ready.
REQ-027 Simultaneous stop and run_len terminal SHALL give a single RUN->DRAIN transition.
REQ-028 start in RUN/DRAIN and stop outside RUN SHALL be ignored.
REQ-029 The run counter SHALL be 16-bit and SHALL not wrap when run_len==0; it saturates at 16'hFFFF.

Reset
REQ-030 While rst_n is low the block SHALL be in IDLE with FIFO empty, LFSR=SEED, a=b=c=0, trace_valid=0, busy=0, done=0, overflow=0, drop_cnt=0.
REQ-031 Reset mid-run SHALL discard all FIFO contents immediately; no done pulse is produced.

Configuration
REQ-032 With ANDCHAIN_TRACE_DROPCNT_EN defined, drop_cnt SHALL implement REQ-024 counting; without it, drop_cnt SHALL be constant 0 and overflow alone SHALL flag drops.

Verification
REQ-033 Reset, start, run_len=1, SEED=16'hACE1, LANES=5 -> first RUN cycle a=5'b00001, b=5'b00111, c=5'b01011; done one cycle after FIFO drained.
REQ-034 run_len=20, DEPTH=16, trace_ready=0 -> 16 entries held, overflow=1, drop_cnt=4 (0 without macro); then trace_ready=1 -> 16 pops, done.
REQ-035 run_len=0, stop asserted after 10 RUN cycles -> exactly 10 entries pushed, busy low after drain.
REQ-036 FIFO full with trace_ready=1 during RUN -> no drops, overflow stays 0.
REQ-037 rst_n low in RUN with 5 entries queued -> trace_valid=0, a=b=c=0, state IDLE next cycle, no done.
REQ-038 start while busy and stop while IDLE -> no state change, no LFSR reload.
